// File: rtl/exu_alu_seq_pkg.sv
// Shared encodings for the sequential ALU: function codes, FSM states and widths.
package exu_alu_seq_pkg;

  localparam int unsigned IsaWidth         = 32;
  localparam int unsigned AluFunctWidth    = 4;
  localparam int unsigned AluSeqStateWidth = 2;

  typedef enum logic [AluFunctWidth-1:0] {
    AluNoFunct    = 4'd0,
    AluAdd        = 4'd1,
    AluSub        = 4'd2,
    AluXor        = 4'd3,
    AluOr         = 4'd4,
    AluAnd        = 4'd5,
    AluEq         = 4'd6,
    AluNeq        = 4'd7,
    AluGreaterEq  = 4'd8,
    AluGreaterEqU = 4'd9,
    AluLessU      = 4'd10,
    AluShiftLL    = 4'd11,
    AluShiftRL    = 4'd12,
    AluShiftRA    = 4'd13
  } alu_funct_e;

  typedef enum logic [AluSeqStateWidth-1:0] {
    AluSeqIdle  = 2'd0,
    AluSeqShift = 2'd1,
    AluSeqDone  = 2'd2
  } alu_seq_state_e;

  function automatic logic is_shift(logic [AluFunctWidth-1:0] funct);
    return (funct == AluShiftLL) || (funct == AluShiftRL) || (funct == AluShiftRA);
  endfunction

endpackage

// File: rtl/exu_alu_seq_if.sv
// Operand/result handshake bundle between the EXU select stage and the sequential ALU.
interface exu_alu_seq_if
  import exu_alu_seq_pkg::*;
#(
  parameter int unsigned Width      = IsaWidth,
  parameter int unsigned FunctWidth = AluFunctWidth
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [Width-1:0]      alu_a;
  logic [Width-1:0]      alu_b;
  logic [FunctWidth-1:0] alu_funct;
  logic                  out_valid;
  logic                  out_ready;
  logic [Width-1:0]      alu_result;

  modport master (
    output in_valid, alu_a, alu_b, alu_funct, out_ready,
    input  in_ready, out_valid, alu_result
  );

  modport slave (
    input  in_valid, alu_a, alu_b, alu_funct, out_ready,
    output in_ready, out_valid, alu_result
  );

endinterface

// File: rtl/exu_alu_shift_unit.sv
// Iterative shifter: loads an operand and amount, then shifts one bit per cycle.
module exu_alu_shift_unit
  import exu_alu_seq_pkg::*;
#(
  parameter int unsigned Width     = IsaWidth,
  parameter int unsigned ShamtBits = $clog2(Width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [Width-1:0]     a_i,
  input  logic [ShamtBits-1:0] shamt_i,
  input  logic                 left_i,
  input  logic                 arith_i,
  output logic [Width-1:0]     next_o,
  output logic                 done_o
);

  logic [Width-1:0]     work_q, work_d;
  logic [ShamtBits-1:0] cnt_q, cnt_d;
  logic                 left_q, arith_q;

  always_comb begin
    next_o = left_q ? {work_q[Width-2:0], 1'b0}
                    : {arith_q & work_q[Width-1], work_q[Width-1:1]};
    work_d = work_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      work_d = a_i;
      cnt_d  = shamt_i;
    end else if (cnt_q != '0) begin
      work_d = next_o;
      cnt_d  = cnt_q - ShamtBits'(1);
    end
  end

  // Asserted on the cycle whose edge performs the final shift.
  assign done_o = (cnt_q == ShamtBits'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      work_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      if (start_i) begin
        left_q  <= left_i;
        arith_q <= arith_i;
      end
    end
  end

endmodule

// File: rtl/exu_alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/compare, bit-serial shifts, valid/ready I/O.
module exu_alu_seq
  import exu_alu_seq_pkg::*;
#(
  parameter int unsigned Width       = IsaWidth,
  parameter int unsigned FunctWidth  = AluFunctWidth,
  parameter int unsigned ShamtBits   = 5
) (
  input  logic          clk,
  input  logic          rst,
  exu_alu_seq_if.slave  bus,
  output logic          busy
);

  alu_seq_state_e       state_q;
  logic [Width-1:0]     result_q;
  logic                 out_valid_q;
  logic [Width-1:0]     a, b, calc, shift_next;
  logic [FunctWidth-1:0] funct;
  logic [ShamtBits-1:0] shamt;
  logic                 accept, start_shift, shift_done;

  assign a      = bus.alu_a;
  assign b      = bus.alu_b;
  assign funct  = bus.alu_funct;
  assign shamt  = b[ShamtBits-1:0];

  assign bus.in_ready   = (state_q == AluSeqIdle) || ((state_q == AluSeqDone) && bus.out_ready);
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign busy           = (state_q == AluSeqShift);

  assign accept      = bus.in_valid && bus.in_ready;
  assign start_shift = accept && is_shift(funct) && (shamt != '0);

  always_comb begin
    calc = '0;
    case (alu_funct_e'(funct))
      AluAdd:        calc = a + b;
      AluSub:        calc = a - b;
      AluXor:        calc = a ^ b;
      AluOr:         calc = a | b;
      AluAnd:        calc = a & b;
      AluEq:         calc = Width'(a == b);
      AluNeq:        calc = Width'(a != b);
      AluGreaterEq:  calc = Width'($signed(a) >= $signed(b));
      AluGreaterEqU: calc = Width'(a >= b);
      AluLessU:      calc = Width'(a < b);
      // Zero-amount shifts bypass the shifter and complete in one cycle.
      AluShiftLL, AluShiftRL, AluShiftRA: calc = a;
      default:       calc = '0;
    endcase
  end

  exu_alu_shift_unit #(
    .Width     (Width),
    .ShamtBits (ShamtBits)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_shift),
    .a_i     (a),
    .shamt_i (shamt),
    .left_i  (funct == AluShiftLL),
    .arith_i (funct == AluShiftRA),
    .next_o  (shift_next),
    .done_o  (shift_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= AluSeqIdle;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        AluSeqIdle, AluSeqDone: begin
          if (accept) begin
            if (start_shift) begin
              state_q     <= AluSeqShift;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= AluSeqDone;
              result_q    <= calc;
              out_valid_q <= 1'b1;
            end
          end else if ((state_q == AluSeqDone) && bus.out_ready) begin
            state_q     <= AluSeqIdle;
            out_valid_q <= 1'b0;
          end
        end
        AluSeqShift: begin
          if (shift_done) begin
            state_q     <= AluSeqDone;
            result_q    <= shift_next;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= AluSeqIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exu_alu_seq.sv
// Directed-vector bench for exu_alu_seq with hand-computed expected results.
module tb_exu_alu_seq;
  import exu_alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  exu_alu_seq_if bus ();

  exu_alu_seq dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready=1, wait for its result and check value, latency and busy time.
  task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_n;
    bus.alu_funct = f;
    bus.alu_a     = a;
    bus.alu_b     = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.alu_a     = ~a;
    bus.alu_b     = b ^ 32'h0000_001f;
    bus.alu_funct = 4'd1;
    lat    = 1;
    busy_n = 0;
    while (!bus.out_valid && lat < 64) begin
      if (busy) busy_n++;
      step();
      lat++;
    end
    check_eq({tag, "_res"}, bus.alu_result, exp_res);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_busy"}, busy_n, exp_lat - 1);
    check_eq({tag, "_inrdy"}, {31'd0, bus.in_ready}, 32'd1);
    step();
    check_eq({tag, "_idle"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_funct = '0;

    // Reset state
    step();
    step();
    check_eq("rst_ov", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_inrdy", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_res", bus.alu_result, 32'd0);
    rst = 1'b1;
    step();

    // Single-cycle and shift ops
    run_op("add", AluAdd, 32'd5, 32'd7, 32'd12, 1);
    run_op("sub", AluSub, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
    run_op("sra4", AluShiftRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
    run_op("sll0", AluShiftLL, 32'h0000_1234, 32'h20, 32'h0000_1234, 1);
    run_op("srl8", AluShiftRL, 32'hF000_0000, 32'd8, 32'h00F0_0000, 9);
    run_op("sll31", AluShiftLL, 32'd1, 32'd31, 32'h8000_0000, 32);
    run_op("ge", AluGreaterEq, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("geu", AluGreaterEqU, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("ltu", AluLessU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("neq", AluNeq, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("eq", AluEq, 32'd5, 32'd5, 32'd1, 1);
    run_op("undef", 4'hF, 32'h1234_5678, 32'h1, 32'd0, 1);
    run_op("nofn", AluNoFunct, 32'h1234_5678, 32'h1, 32'd0, 1);

    // Back-pressure: result holds, new request ignored
    bus.out_ready = 1'b0;
    bus.alu_funct = AluAdd;
    bus.alu_a     = 32'd10;
    bus.alu_b     = 32'd20;
    bus.in_valid  = 1'b1;
    step();
    bus.alu_funct = AluSub;
    bus.alu_a     = 32'd100;
    bus.alu_b     = 32'd1;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_ov", {31'd0, bus.out_valid}, 32'd1);
      check_eq("bp_res", bus.alu_result, 32'd30);
      check_eq("bp_inrdy", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("bp_res_rel", bus.alu_result, 32'd30);
    step();
    check_eq("bp_idle_ov", {31'd0, bus.out_valid}, 32'd0);
    check_eq("bp_idle_inrdy", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back without bubbles, then into a shift
    bus.alu_a     = 32'hFF00_FF00;
    bus.alu_b     = 32'h0F0F_0F0F;
    bus.alu_funct = AluXor;
    bus.in_valid  = 1'b1;
    step();
    bus.alu_funct = AluAnd;
    check_eq("b2b_xor_ov", {31'd0, bus.out_valid}, 32'd1);
    check_eq("b2b_xor", bus.alu_result, 32'hF00F_F00F);
    check_eq("b2b_inrdy", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.alu_funct = AluOr;
    check_eq("b2b_and_ov", {31'd0, bus.out_valid}, 32'd1);
    check_eq("b2b_and", bus.alu_result, 32'h0F00_0F00);
    step();
    bus.alu_funct = AluShiftLL;
    bus.alu_a     = 32'd3;
    bus.alu_b     = 32'd2;
    check_eq("b2b_or_ov", {31'd0, bus.out_valid}, 32'd1);
    check_eq("b2b_or", bus.alu_result, 32'hFF0F_FF0F);
    step();
    bus.in_valid = 1'b0;
    check_eq("b2b_sh_ov", {31'd0, bus.out_valid}, 32'd0);
    check_eq("b2b_sh_busy", {31'd0, busy}, 32'd1);
    step();
    check_eq("b2b_sh_busy2", {31'd0, busy}, 32'd1);
    step();
    check_eq("b2b_sh_ov2", {31'd0, bus.out_valid}, 32'd1);
    check_eq("b2b_sh_res", bus.alu_result, 32'd12);
    step();

    // Reset during a 10-bit shift aborts it
    bus.alu_funct = AluShiftLL;
    bus.alu_a     = 32'd1;
    bus.alu_b     = 32'd10;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("abort_ov", {31'd0, bus.out_valid}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_inrdy", {31'd0, bus.in_ready}, 32'd1);
    check_eq("abort_res", bus.alu_result, 32'd0);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check_eq("abort_no_result", seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_alu_seq.md
Name: exu_alu_seq

Overview:
- Multi-cycle ALU datapath directly downstream of the EXU operand/function select stage.
- Consumes alu_a, alu_b and alu_funct, computes alu_result, and returns it to the EXU/WBU.
- Single-cycle for arithmetic, logic and compare ops; iterative (1 bit/cycle) for shifts to save area.
- valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, `ISA_WIDTH (32), operand/result width.
- FUNCT_WIDTH, `ALU_FUNCT_WIDTH, function code width.
- SHAMT_BITS, 5, low bits of alu_b used as shift amount (log2 WIDTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  operands and funct valid this cycle.
- in_ready  out  1  block can accept a new operation.
- alu_a  in  WIDTH  operand A.
- alu_b  in  WIDTH  operand B; low SHAMT_BITS give the shift amount for shift ops.
- alu_funct  in  FUNCT_WIDTH  `ALU_FUNCT code.
- out_valid  out  1  alu_result valid.
- out_ready  in  1  consumer accepts the result.
- alu_result  out  WIDTH  registered result.
- busy  out  1  high while in SHIFT state.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-low.
- Reset values (rst=0 at posedge): state=IDLE, out_valid=0, alu_result=0, busy=0, shift counter=0.
- Reset mid-operation aborts the operation; no result is emitted.
- States:
  - IDLE: no op in flight.
  - SHIFT: iterative shift in progress.
  - DONE: result held.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational; no dependence on in_valid.
- Accept occurs when in_valid && in_ready; operands and funct are captured at that edge.
- Non-shift op accepted at edge T: result registered at T and state goes to DONE, so out_valid=1 in cycle T+1.
- Shift op (SHIFT_L_L, SHIFT_R_L, SHIFT_R_A) with amount k = alu_b[SHAMT_BITS-1:0]:
  - k==0: result=alu_a, go to DONE; out_valid at T+1.
  - k>0: go to SHIFT with counter=k and working reg=alu_a.
  - In SHIFT, each cycle shifts 1 bit and decrements the counter. On the edge where the counter goes 1->0, go to DONE.
  - out_valid at T+1+k.
  - SHIFT_R_A replicates bit WIDTH-1; logical shifts fill with 0.
- Function results (WIDTH bits, modulo 2^WIDTH):
  - ADD: a+b.
  - SUB: a-b.
  - XOR, OR, AND: bitwise.
  - EQ, NEQ, GREATER_EQ (signed), GREATER_EQ_U, LESS_U: result is {0..,1} or 0.
  - NO_FUNCT and any undefined code: 0.
- DONE:
  - Hold out_valid=1 and alu_result stable until out_ready=1.
  - On out_ready with no new accept, go to IDLE and drop out_valid.
  - On out_ready with a simultaneous accept, start the new op with no bubble: out_valid stays 1 next cycle with the new result for non-shift ops and k==0 shifts; for k>0 shifts, out_valid drops during SHIFT.
- in_valid is ignored in SHIFT, and in DONE when out_ready=0.
- Input port changes after accept do not affect the result.
- busy = (state==SHIFT).

Decomposition:
- The `ALU_FUNCT_* codes and `ALU_FUNCT_WIDTH already live in the shared inst/config headers; reuse them unchanged.
- Add the state encodings (ALU_SEQ_IDLE/SHIFT/DONE) and the state width to the same header.
- One sub-module: exu_alu_shift_unit, holding the working register, counter, 1-bit shift per cycle and a done pulse.
- The top level holds the FSM, the combinational single-cycle ops and the result register.

Test Plan:
- ADD a=5, b=7, in_valid at T with out_ready=1: out_valid at T+1 with result 12, and in_ready=1 in that cycle. SUB a=0, b=1 gives 0xFFFFFFFF.
- SHIFT_R_A a=0x80000000, b=4: busy for 4 cycles, out_valid at T+5 with 0xF8000000. SHIFT_L_L with b=0x20 (k=0) gives a at T+1.
- Compare ops with a=0xFFFFFFFF, b=1: GREATER_EQ→0, GREATER_EQ_U→1, LESS_U→0, NEQ→1. An undefined funct gives 0.
- Back-pressure: ADD result with out_ready=0 for 3 cycles: out_valid and result hold, in_ready=0, a new in_valid is not accepted. Raise out_ready: handshake completes and state returns to IDLE.
- Back-to-back: XOR accepted in DONE while out_ready=1: no bubble, consecutive out_valid cycles each with the correct result.
- Reset: assert rst=0 during a k=10 shift at cycle 3: the next cycle shows out_valid=0, busy=0, in_ready=1, alu_result=0, and no result is ever emitted for the aborted op.
